ec_scalar_mult_ctrl: RTL and testbench
======================================

// Module: ec_scalar_mult_ctrl
// PURPOSE
//  Sequencer that drives the projective point adder (EC_adder) to compute R = k*P.
//  Uses MSB-first double-and-add. A doubling is an adder call with P = Q = R.
//  Owns the accumulator R and the adder operand muxes. Sits between the ECDSA
//  verify top-level FSM and the single shared adder instance.
// PARAMETERS
//  K_W   381  scalar width in bits; also the number of loop iterations
//  C_W   381  coordinate width (Xp..Zq, M)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous reset, active-high
//  start      in   1    1-cycle request; sampled only in IDLE
//  k          in   K_W  scalar; latched on accepted start
//  Xb,Yb,Zb   in   C_W  base point P; latched on accepted start
//  M          in   C_W  modulus; passed straight to the adder
//  add_start  out  1    1-cycle pulse to the adder start input
//  add_Xp..Zp out  C_W  adder operand P (always R)
//  add_Xq..Zq out  C_W  adder operand Q (R when doubling, base when adding)
//  add_Xr..Zr in   C_W  adder result
//  add_done   in   1    adder result valid
//  Xr,Yr,Zr   out  C_W  final k*P; held until the next accepted start
//  busy       out  1    high from LOAD through the last capture
//  done       out  1    1-cycle pulse when Xr/Yr/Zr are valid
// BEHAVIOUR
//  Reset (async, any state):
//   - state = IDLE
//   - R, Xr, Yr, Zr, latched k and base cleared to 0
//   - busy = done = add_start = 0
//   - Reset mid-operation abandons the op. Later add_done pulses are ignored in IDLE.
//  States: IDLE -> LOAD -> DBL -> WDBL -> (ADD -> WADD) -> NEXT -> ... -> FIN -> IDLE
//   IDLE: start = 1 -> LOAD. start while busy is ignored (no queueing).
//   LOAD (1 cycle): latch k and base; R = (0,1,0), the point at infinity; i = K_W-1.
//   DBL  (1 cycle): add_start = 1 with P = Q = R -> WDBL.
//   WDBL: wait for add_done. add_done is sampled only from the cycle after
//         add_start, so a level-high done cannot short-circuit the wait.
//         On add_done: R <= add_result.
//         If k[i] = 1 -> ADD, else -> NEXT.
//   ADD  (1 cycle): add_start = 1 with P = R, Q = base -> WADD.
//   WADD: same capture rule as WDBL -> NEXT.
//   NEXT (merged into capture cycle, no extra cycle):
//         if i == 0 -> FIN, else i = i-1 -> DBL.
//   FIN  (1 cycle): Xr/Yr/Zr <= R; done = 1; busy = 0 -> IDLE.
//  Operand stability: add_X*/Y*/Z* are stable from the add_start cycle through
//   the capture cycle. Operands are don't-care but registered in all other states.
//  Latency: with add_start in cycle t and add_done in cycle t+L, each op takes L+1 cycles.
//   - start sampled at edge 0; LOAD is cycle 1; first add_start is cycle 2.
//   - done is high in cycle 2 + n_ops*(L+1), where n_ops = K_W + popcount(k).
//  k = 0: only doublings run; result is (0,1,0) under a real adder.
//  No arithmetic in this block; widths pass through unchanged.
//  add_start and add_done both high in one cycle never means completion of the new op.
// TESTING (bench adder model: X = Xp+Xq, Y = Yp+Yq, Z = Zp+Zq, add_done pulse at t+3)
//  1. K_W=4, k=4'b0101, P=(3,4,1)
//     -> R=(15,36,5); done in cycle 26; add_start pulses = 6; busy low in cycle 26.
//  2. K_W=4, k=0, P=(3,4,1)
//     -> R=(0,16,0), i.e. 2^K_W in Y; 4 add_start pulses; done in cycle 18.
//  3. K_W=4, k=4'b1111, P=(1,1,1)
//     -> R=(15,31,15); 8 ops; Q operand equals base on every ADD.
//  4. start re-pulsed at cycles 5 and 10 of run 1
//     -> ignored; result and timing identical to scenario 1.
//  5. rst asserted at cycle 9 of run 1, add_done still pulses afterwards
//     -> IDLE, outputs 0, no add_start or done; a new start then gives scenario 1 results.
//  6. Adder model with add_done tied high
//     -> capture happens in the cycle after each add_start; no op is skipped.

Source files
------------

// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl
//   Double-and-add sequencer that computes R = k*P by driving one shared
//   projective point adder. The scalar is scanned MSB first: every bit costs
//   one doubling (an adder call with P = Q = R), and every set bit costs one
//   extra addition with Q = base point. No arithmetic happens here.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle request, accepted only while idle
//   k                   scalar, latched when start is accepted
//   Xb, Yb, Zb          base point P, latched when start is accepted
//   M                   modulus, forwarded unchanged on add_M
//   add_start           one-cycle launch pulse to the adder
//   add_Xp..add_Zp      adder operand P (always the accumulator R)
//   add_Xq..add_Zq      adder operand Q (R for doublings, base for additions)
//   add_M               modulus forwarded to the adder
//   add_Xr..add_Zr      adder result
//   add_done            adder result valid
//   Xr, Yr, Zr          final k*P, held until the next accepted start
//   busy                high from LOAD through the last result capture
//   done                one-cycle pulse while Xr/Yr/Zr first show the result

module ec_scalar_mult_ctrl #(
  parameter int K_W = 381,
  parameter int C_W = 381
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K_W-1:0] k,
  input  logic [C_W-1:0] Xb,
  input  logic [C_W-1:0] Yb,
  input  logic [C_W-1:0] Zb,
  input  logic [C_W-1:0] M,
  output logic           add_start,
  output logic [C_W-1:0] add_Xp,
  output logic [C_W-1:0] add_Yp,
  output logic [C_W-1:0] add_Zp,
  output logic [C_W-1:0] add_Xq,
  output logic [C_W-1:0] add_Yq,
  output logic [C_W-1:0] add_Zq,
  output logic [C_W-1:0] add_M,
  input  logic [C_W-1:0] add_Xr,
  input  logic [C_W-1:0] add_Yr,
  input  logic [C_W-1:0] add_Zr,
  input  logic           add_done,
  output logic [C_W-1:0] Xr,
  output logic [C_W-1:0] Yr,
  output logic [C_W-1:0] Zr,
  output logic           busy,
  output logic           done
);

  localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DBL,
    WDBL,
    ADD,
    WADD,
    FIN
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [K_W-1:0] kreg;
  logic [C_W-1:0] bx, by, bz;
  logic [C_W-1:0] rx, ry, rz;
  logic [C_W-1:0] qx, qy, qz;

  // Operand P is the accumulator register itself. R only changes on a
  // capture edge, so P is automatically stable from add_start through the
  // capture cycle. Q has its own register, loaded on every launch edge.
  assign add_Xp = rx;
  assign add_Yp = ry;
  assign add_Zp = rz;
  assign add_Xq = qx;
  assign add_Yq = qy;
  assign add_Zq = qz;
  assign add_M  = M;

  // Main sequencer. Each launch edge loads the Q operand and raises
  // add_start for exactly one cycle (the DBL or ADD state). The wait states
  // are only entered the cycle after add_start, so a stale or level-high
  // add_done can never complete an operation early. The NEXT step is folded
  // into the capture edge: after a capture we either launch the next
  // doubling right away or finish. The final result goes to Xr/Yr/Zr on the
  // last capture edge, so it is already visible while done is high in FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      kreg      <= '0;
      bx        <= '0;
      by        <= '0;
      bz        <= '0;
      rx        <= '0;
      ry        <= '0;
      rz        <= '0;
      qx        <= '0;
      qy        <= '0;
      qz        <= '0;
      Xr        <= '0;
      Yr        <= '0;
      Zr        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      add_start <= 1'b0;
    end else begin
      add_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kreg  <= k;
            bx    <= Xb;
            by    <= Yb;
            bz    <= Zb;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          // Start from the point at infinity (0,1,0) and double it first.
          rx        <= '0;
          ry        <= C_W'(1);
          rz        <= '0;
          qx        <= '0;
          qy        <= C_W'(1);
          qz        <= '0;
          idx       <= IW'(K_W - 1);
          add_start <= 1'b1;
          state     <= DBL;
        end
        DBL: state <= WDBL;
        WDBL: begin
          if (add_done) begin
            rx <= add_Xr;
            ry <= add_Yr;
            rz <= add_Zr;
            if (kreg[idx]) begin
              qx        <= bx;
              qy        <= by;
              qz        <= bz;
              add_start <= 1'b1;
              state     <= ADD;
            end else if (idx == '0) begin
              Xr    <= add_Xr;
              Yr    <= add_Yr;
              Zr    <= add_Zr;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              idx       <= idx - 1'b1;
              qx        <= add_Xr;
              qy        <= add_Yr;
              qz        <= add_Zr;
              add_start <= 1'b1;
              state     <= DBL;
            end
          end
        end
        ADD: state <= WADD;
        WADD: begin
          if (add_done) begin
            rx <= add_Xr;
            ry <= add_Yr;
            rz <= add_Zr;
            if (idx == '0) begin
              Xr    <= add_Xr;
              Yr    <= add_Yr;
              Zr    <= add_Zr;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              idx       <= idx - 1'b1;
              qx        <= add_Xr;
              qy        <= add_Yr;
              qz        <= add_Zr;
              add_start <= 1'b1;
              state     <= DBL;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// tb_ec_scalar_mult_ctrl
//   Directed bench for the double-and-add sequencer with K_W = 4. The adder
//   is replaced by a toy model that adds coordinates component-wise, so R
//   simply accumulates k-weighted sums that are easy to compute by hand.

module tb_ec_scalar_mult_ctrl;

  localparam int K_W = 4;
  localparam int C_W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [K_W-1:0] k;
  logic [C_W-1:0] Xb, Yb, Zb, M;
  logic           add_start;
  logic [C_W-1:0] add_Xp, add_Yp, add_Zp;
  logic [C_W-1:0] add_Xq, add_Yq, add_Zq;
  logic [C_W-1:0] add_M;
  logic [C_W-1:0] add_Xr, add_Yr, add_Zr;
  logic           add_done;
  logic [C_W-1:0] Xr, Yr, Zr;
  logic           busy;
  logic           done;

  logic           tie_high = 1'b0;
  logic           stray    = 1'b0;

  int tests_run  = 0;
  int fail_count = 0;
  int cycle_count = 0;

  // Results collected by applyStimulus for the most recent run.
  int             done_cycle;
  int             n_add_start;
  int             n_dbl;
  int             n_base;
  int             busy_err;
  int             unstable;
  int             extra_pulses;
  logic           busy_at_done;
  logic [C_W-1:0] res_x, res_y, res_z;

  ec_scalar_mult_ctrl #(.K_W(K_W), .C_W(C_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k         (k),
    .Xb        (Xb),
    .Yb        (Yb),
    .Zb        (Zb),
    .M         (M),
    .add_start (add_start),
    .add_Xp    (add_Xp),
    .add_Yp    (add_Yp),
    .add_Zp    (add_Zp),
    .add_Xq    (add_Xq),
    .add_Yq    (add_Yq),
    .add_Zq    (add_Zq),
    .add_M     (add_M),
    .add_Xr    (add_Xr),
    .add_Yr    (add_Yr),
    .add_Zr    (add_Zr),
    .add_done  (add_done),
    .Xr        (Xr),
    .Yr        (Yr),
    .Zr        (Zr),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock and a cycle counter used to timestamp events.
  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Toy adder: sums captured at the add_start edge, done pulse three cycles
  // after add_start. The pipeline is deliberately not reset, so a pulse
  // launched before a reset still arrives afterwards. In tie-high mode the
  // result is the combinational sum and add_done is stuck at 1.
  logic           pd1 = 1'b0, pd2 = 1'b0, pipe_done = 1'b0;
  logic [C_W-1:0] px = '0, py = '0, pz = '0;

  always @(posedge clk) begin
    pd1       <= add_start;
    pd2       <= pd1;
    pipe_done <= pd2;
    if (add_start) begin
      px <= add_Xp + add_Xq;
      py <= add_Yp + add_Yq;
      pz <= add_Zp + add_Zq;
    end
  end

  assign add_done = tie_high | pipe_done | stray;
  assign add_Xr   = tie_high ? add_Xp + add_Xq : px;
  assign add_Yr   = tie_high ? add_Yp + add_Yq : py;
  assign add_Zr   = tie_high ? add_Zp + add_Zq : pz;

  // Single comparison point: counts the test and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launches one scalar multiplication and watches it on falling edges:
  // counts launches, classifies each one as a doubling (Q == P) or a base
  // addition (Q == base), checks operand stability while waiting, checks
  // busy, and records the done cycle and result. Cycle 1 is the LOAD cycle.
  task automatic applyStimulus(input logic [K_W-1:0] k_in,
                               input logic [C_W-1:0] bxi,
                               input logic [C_W-1:0] byi,
                               input logic [C_W-1:0] bzi,
                               input bit repulse);
    int             n0;
    int             cyc;
    bit             seen_first;
    bit             finished;
    logic [C_W-1:0] l_xp, l_yp, l_zp, l_xq, l_yq, l_zq;
    done_cycle   = -1;
    n_add_start  = 0;
    n_dbl        = 0;
    n_base       = 0;
    busy_err     = 0;
    unstable     = 0;
    extra_pulses = 0;
    busy_at_done = 1'bx;
    res_x        = 'x;
    res_y        = 'x;
    res_z        = 'x;
    seen_first   = 1'b0;
    finished     = 1'b0;
    l_xp = '0; l_yp = '0; l_zp = '0; l_xq = '0; l_yq = '0; l_zq = '0;
    @(negedge clk);
    k     = k_in;
    Xb    = bxi;
    Yb    = byi;
    Zb    = bzi;
    start = 1'b1;
    @(posedge clk);
    #1;
    n0 = cycle_count;
    for (int s = 0; s < 200 && !finished; s++) begin
      @(negedge clk);
      cyc   = cycle_count - n0 + 1;
      start = repulse && (cyc == 5 || cyc == 10);
      if (add_start) begin
        n_add_start++;
        if (add_Xq == add_Xp && add_Yq == add_Yp && add_Zq == add_Zp)
          n_dbl++;
        else if (add_Xq == bxi && add_Yq == byi && add_Zq == bzi)
          n_base++;
        l_xp = add_Xp; l_yp = add_Yp; l_zp = add_Zp;
        l_xq = add_Xq; l_yq = add_Yq; l_zq = add_Zq;
        seen_first = 1'b1;
      end else if (busy && seen_first) begin
        if (add_Xp != l_xp || add_Yp != l_yp || add_Zp != l_zp ||
            add_Xq != l_xq || add_Yq != l_yq || add_Zq != l_zq)
          unstable++;
      end
      if (done) begin
        done_cycle   = cyc;
        busy_at_done = busy;
        res_x        = Xr;
        res_y        = Yr;
        res_z        = Zr;
        finished     = 1'b1;
      end else if (busy !== 1'b1) begin
        busy_err++;
      end
    end
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || add_start) extra_pulses++;
    end
  endtask

  // Checks shared by every completed run.
  task automatic checkRun(input string tag, input int exp_cycle,
                          input int exp_ops, input logic [C_W-1:0] ex,
                          input logic [C_W-1:0] ey, input logic [C_W-1:0] ez);
    checkOutput({tag, ".done_cycle"}, done_cycle, exp_cycle);
    checkOutput({tag, ".add_starts"}, n_add_start, exp_ops);
    checkOutput({tag, ".Xr"}, res_x, ex);
    checkOutput({tag, ".Yr"}, res_y, ey);
    checkOutput({tag, ".Zr"}, res_z, ez);
    checkOutput({tag, ".busy_at_done"}, busy_at_done, 0);
    checkOutput({tag, ".busy_err"}, busy_err, 0);
    checkOutput({tag, ".unstable"}, unstable, 0);
    checkOutput({tag, ".extra_pulses"}, extra_pulses, 0);
    checkOutput({tag, ".Xr_held"}, Xr, ex);
  endtask

  // Watchdog in case the stimulus ever stalls on a clock it never gets.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int n0;
    int activity;
    rst   = 1'b1;
    start = 1'b0;
    k     = '0;
    Xb    = '0;
    Yb    = '0;
    Zb    = '0;
    M     = 16'hFFF1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.add_start", add_start, 0);
    checkOutput("reset.Xr", Xr, 0);
    checkOutput("reset.Yp", add_Yp, 0);
    checkOutput("add_M", add_M, 16'hFFF1);
    @(negedge clk);
    rst = 1'b0;

    // k = 0101, P = (3,4,1): 6 ops of 4 cycles, result (15,36,5).
    applyStimulus(4'b0101, 16'd3, 16'd4, 16'd1, 1'b0);
    checkRun("s1", 26, 6, 16'd15, 16'd36, 16'd5);
    checkOutput("s1.dbl", n_dbl, 4);
    checkOutput("s1.add_base", n_base, 2);

    // k = 0: four doublings of (0,1,0) give (0,16,0).
    applyStimulus(4'b0000, 16'd3, 16'd4, 16'd1, 1'b0);
    checkRun("s2", 18, 4, 16'd0, 16'd16, 16'd0);

    // k = 1111, P = (1,1,1): every bit adds the base point.
    applyStimulus(4'b1111, 16'd1, 16'd1, 16'd1, 1'b0);
    checkRun("s3", 34, 8, 16'd15, 16'd31, 16'd15);
    checkOutput("s3.dbl", n_dbl, 4);
    checkOutput("s3.add_base", n_base, 4);

    // Extra start pulses during a run must be ignored.
    applyStimulus(4'b0101, 16'd3, 16'd4, 16'd1, 1'b1);
    checkRun("s4", 26, 6, 16'd15, 16'd36, 16'd5);

    // Reset in cycle 9 of a run, then a stray add_done while idle.
    @(negedge clk);
    k     = 4'b0101;
    Xb    = 16'd3;
    Yb    = 16'd4;
    Zb    = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    n0 = cycle_count;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("s5.cycle_before_rst", cycle_count - n0 + 1, 9);
    checkOutput("s5.busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("s5.busy", busy, 0);
    checkOutput("s5.done", done, 0);
    checkOutput("s5.add_start", add_start, 0);
    checkOutput("s5.Xr", Xr, 0);
    checkOutput("s5.Yr", Yr, 0);
    checkOutput("s5.Zr", Zr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    activity = 0;
    repeat (10) begin
      @(negedge clk);
      if (add_start || done || busy) activity++;
    end
    checkOutput("s5.idle_activity", activity, 0);
    applyStimulus(4'b0101, 16'd3, 16'd4, 16'd1, 1'b0);
    checkRun("s5.rerun", 26, 6, 16'd15, 16'd36, 16'd5);

    // add_done stuck high: each op takes 2 cycles, none skipped.
    tie_high = 1'b1;
    applyStimulus(4'b0101, 16'd3, 16'd4, 16'd1, 1'b0);
    tie_high = 1'b0;
    checkOutput("s6.done_cycle", done_cycle, 14);
    checkOutput("s6.add_starts", n_add_start, 6);
    checkOutput("s6.dbl", n_dbl, 4);
    checkOutput("s6.add_base", n_base, 2);
    checkOutput("s6.Xr", res_x, 15);
    checkOutput("s6.Yr", res_y, 36);
    checkOutput("s6.Zr", res_z, 5);
    checkOutput("s6.unstable", unstable, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
